ntt_butterfly: RTL and testbench

NTT_BUTTERFLY -- requirements
Module: ntt_butterfly

---
 rtl/ntt_pkg.sv | 17 +
 rtl/ntt_butterfly_mont_mul.sv | 83 ++++++++
 rtl/ntt_butterfly.sv | 119 +++++++++++
 tb/tb_ntt_butterfly.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and delay-line record for the NTT butterfly.
`timescale 1ns/1ps
package ntt_pkg;

    localparam int W_DEF      = 32;
    localparam int M_BITS_DEF = 8;
    localparam int IDX_W_DEF  = 10;
    localparam int N_DEF      = W_DEF / M_BITS_DEF;

    // One slot of the u/valid/idx delay line that runs beside the multiplier.
    typedef struct packed {
        logic                 valid;
        logic [IDX_W_DEF-1:0] idx;
        logic [W_DEF-1:0]     u;
    } dly_t;

endpackage

// File: rtl/ntt_butterfly_mont_mul.sv
// Digit-serial Montgomery multiplier, one radix-2^M_BITS digit of a per stage.
// p = a*b*2^-W mod m after exactly W/M_BITS cycles; a, b < m required.
`timescale 1ns/1ps
module mont_mul #(
    parameter int W      = 32,
    parameter int M_BITS = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [W-1:0]      m,
    input  logic [M_BITS-1:0] m_inv,
    output logic [W-1:0]      p
);

    localparam int N  = W / M_BITS;
    localparam int TW = W + M_BITS + 1;

    logic [W:0]   t_reg  [N];
    logic [W:0]   t_next [N];
    logic [W-1:0] a_reg  [N];
    logic [W-1:0] a_next [N];
    logic [W-1:0] b_reg  [N];
    logic [W-1:0] b_next [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            logic [W:0]        t_in;
            logic [W-1:0]      a_in;
            logic [W-1:0]      b_in;
            logic [M_BITS-1:0] a_dig;
            logic [M_BITS-1:0] q;
            logic [TW-1:0]     acc;
            logic [TW-1:0]     acc2;
            logic [W:0]        t_red;

            if (gi == 0) begin : g_first
                assign t_in = '0;
                assign a_in = a;
                assign b_in = b;
            end else begin : g_rest
                assign t_in = t_reg[gi-1];
                assign a_in = a_reg[gi-1];
                assign b_in = b_reg[gi-1];
            end

            // Partial result stays below 2m, so W+1 bits hold it between stages.
            assign a_dig = a_in[gi*M_BITS +: M_BITS];
            assign acc   = TW'(t_in) + TW'(a_dig) * TW'(b_in);
            assign q     = acc[M_BITS-1:0] * m_inv;
            assign acc2  = acc + TW'(q) * TW'(m);
            assign t_red = (W+1)'(acc2 >> M_BITS);

            if (gi == N - 1) begin : g_final
                assign t_next[gi] = (t_red >= {1'b0, m}) ? t_red - {1'b0, m} : t_red;
            end else begin : g_mid
                assign t_next[gi] = t_red;
            end

            assign a_next[gi] = a_in;
            assign b_next[gi] = b_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (srst) begin
                t_reg[i] <= '0;
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end else begin
                t_reg[i] <= t_next[i];
                a_reg[i] <= a_next[i];
                b_reg[i] <= b_next[i];
            end
        end
    end

    assign p = W'(t_reg[N-1]);

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Cooley-Tukey butterfly: out0 = u + v*w', out1 = u - v*w' (mod M).
// Latency is the multiplier depth plus one registered add/sub stage.
`timescale 1ns/1ps
module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int M_BITS = M_BITS_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [W-1:0]      u,
    input  logic [W-1:0]      v,
    input  logic [W-1:0]      w,
    input  logic [W-1:0]      M,
    input  logic [M_BITS-1:0] M_inv,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    output logic [W-1:0]      out0,
    output logic [W-1:0]      out1,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy
);

    localparam int N = W / M_BITS;

    dly_t         dly_in;
    dly_t         dly_reg [N];
    dly_t         dly_tail;
    logic         mul_srst;
    logic [W-1:0] p;
    logic [W:0]   sum;
    logic [W-1:0] out0_next;
    logic [W-1:0] out1_next;
    logic         busy_next;

    logic             out_valid_reg;
    logic [W-1:0]     out0_reg;
    logic [W-1:0]     out1_reg;
    logic [IDX_W-1:0] out_idx_reg;

    assign mul_srst = ~rst_n;

    mont_mul #(
        .W      (W),
        .M_BITS (M_BITS)
    ) u_mont_mul (
        .clk   (clk),
        .srst  (mul_srst),
        .a     (v),
        .b     (w),
        .m     (M),
        .m_inv (M_inv),
        .p     (p)
    );

    always_comb begin
        dly_in       = '0;
        dly_in.valid = in_valid;
        dly_in.idx   = in_idx;
        dly_in.u     = u;
    end

    // Same depth as the multiplier so dly_tail lines up with p.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                dly_reg[i] <= '0;
            end
        end else begin
            dly_reg[0] <= dly_in;
            for (int i = 1; i < N; i++) begin
                dly_reg[i] <= dly_reg[i-1];
            end
        end
    end

    assign dly_tail = dly_reg[N-1];

    always_comb begin
        sum       = {1'b0, dly_tail.u} + {1'b0, p};
        out0_next = (sum >= {1'b0, M}) ? W'(sum - {1'b0, M}) : W'(sum);
        // Borrow case adds M first so the W+1-bit intermediate never goes negative.
        out1_next = (dly_tail.u >= p) ? dly_tail.u - p
                                      : W'({1'b0, dly_tail.u} + {1'b0, M} - {1'b0, p});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out0_reg      <= '0;
            out1_reg      <= '0;
            out_idx_reg   <= '0;
        end else begin
            out_valid_reg <= dly_tail.valid;
            if (dly_tail.valid) begin
                out0_reg    <= out0_next;
                out1_reg    <= out1_next;
                out_idx_reg <= dly_tail.idx;
            end
        end
    end

    always_comb begin
        busy_next = out_valid_reg;
        for (int i = 0; i < N; i++) begin
            busy_next = busy_next | dly_reg[i].valid;
        end
    end

    assign out_valid = out_valid_reg;
    assign out0      = out0_reg;
    assign out1      = out1_reg;
    assign out_idx   = out_idx_reg;
    assign busy      = busy_next;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Directed and randomized checks of ntt_butterfly at default parameters, M = 7681.
`timescale 1ns/1ps
module tb_ntt_butterfly;

    localparam logic [31:0] MOD   = 32'd7681;
    localparam logic [31:0] MONT1 = 32'd5569;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] u, v, w, M;
    logic [7:0]  M_inv;
    logic [9:0]  in_idx;
    logic        out_valid;
    logic [31:0] out0, out1;
    logic [9:0]  out_idx;
    logic        busy;

    ntt_butterfly dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .u         (u),
        .v         (v),
        .w         (w),
        .M         (M),
        .M_inv     (M_inv),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out0      (out0),
        .out1      (out1),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_no;
        logic [9:0]  idx;
        logic [31:0] o0;
        logic [31:0] o1;
    } exp_t;

    typedef struct {
        logic [31:0] u;
        logic [31:0] v;
        logic [31:0] w;
        logic [9:0]  idx;
        logic [31:0] o0;
        logic [31:0] o1;
    } vec_t;

    exp_t            exp_q[$];
    vec_t            vecs[8];
    int unsigned     edge_cnt = 0;
    int              n_vec = 0;
    int              n_err = 0;
    longint unsigned rinv;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_p(input logic [31:0] a, input logic [31:0] b);
        longint unsigned t;
        t = (longint'(a) * longint'(b)) % longint'(MOD);
        t = (t * rinv) % longint'(MOD);
        return t[31:0];
    endfunction

    // Drives at the current (negedge) instant; sampled at the next posedge.
    task automatic drive(input logic [31:0] du, input logic [31:0] dv, input logic [31:0] dw,
                         input logic [9:0] di, input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        in_valid = 1'b1;
        u = du; v = dv; w = dw; in_idx = di;
        e.edge_no = edge_cnt + 5;
        e.idx = di; e.o0 = e0; e.o1 = e1;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] du, input logic [31:0] dv, input logic [31:0] dw,
                        input logic [9:0] di, input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        drive(du, dv, dw, di, e0, e1);
    endtask

    task automatic send_rand(input logic [9:0] di);
        logic [31:0] ru, rv, rw, pp;
        ru = $urandom_range(7680, 0);
        rv = $urandom_range(7680, 0);
        rw = $urandom_range(7680, 0);
        pp = ref_p(rv, rw);
        send(ru, rv, rw, di, (ru + pp) % MOD, (ru + MOD - pp) % MOD);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        u = $urandom; v = $urandom; w = $urandom;
        in_idx = 10'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle();
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out_valid: got idx %0d out0 %0d out1 %0d, expected no output",
                         out_idx, out0, out1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn idx=%0d out0=%0d out1=%0d at edge %0d", out_idx, out0, out1, edge_cnt);
                chk("latency_edge", edge_cnt, e.edge_no);
                chk("out_idx", out_idx, e.idx);
                chk("out0", out0, e.o0);
                chk("out1", out1, e.o1);
                chk("out0_below_M", out0 < MOD, 1);
                chk("out1_below_M", out1 < MOD, 1);
            end
        end
    end

    initial begin
        int unsigned e_last;

        // Inverse of 2 mod 7681 is 3841; R^-1 = 3841^32 mod M.
        rinv = 1;
        repeat (32) rinv = (rinv * 64'd3841) % 64'd7681;

        vecs[0] = '{u: 100,  v: 50,   w: MONT1,    idx: 3,    o0: 150,  o1: 50};
        vecs[1] = '{u: 7000, v: 1000, w: MONT1,    idx: 5,    o0: 319,  o1: 6000};
        vecs[2] = '{u: 10,   v: 20,   w: MONT1,    idx: 7,    o0: 30,   o1: 7671};
        vecs[3] = '{u: 1234, v: 4321, w: 0,        idx: 0,    o0: 1234, o1: 1234};
        vecs[4] = '{u: 7680, v: 7680, w: MONT1,    idx: 1023, o0: 7679, o1: 0};
        vecs[5] = '{u: 0,    v: 1,    w: MONT1,    idx: 512,  o0: 1,    o1: 7680};
        vecs[6] = '{u: 10,   v: 3,    w: 32'd3457, idx: 42,   o0: 16,   o1: 4};
        vecs[7] = '{u: 0,    v: 0,    w: MONT1,    idx: 1,    o0: 0,    o1: 0};

        M = MOD; M_inv = 8'd255;
        rst_n = 1'b0; in_valid = 1'b1;
        u = 32'hDEAD_BEEF; v = 32'h1234_5678; w = 32'hCAFE_F00D; in_idx = 10'h3FF;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out0", out0, 0);
        chk("reset_out1", out1, 0);
        chk("reset_out_idx", out_idx, 0);
        rst_n = 1'b1;
        in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].u, vecs[i].v, vecs[i].w, vecs[i].idx, vecs[i].o0, vecs[i].o1);
            drain();
        end

        // Eight back-to-back, then busy must drop one cycle after the last output.
        for (int i = 0; i < 8; i++) begin
            send(32'(100 + i), 32'(i), MONT1, 10'(i), 32'(100 + 2 * i), 32'd100);
        end
        e_last = edge_cnt;
        repeat (5) idle();
        chk("b2b_last_out_valid", out_valid, 1);
        chk("b2b_busy_at_last", busy, 1);
        chk("b2b_elapsed", edge_cnt - e_last, 5);
        idle();
        chk("b2b_out_valid_after", out_valid, 0);
        chk("b2b_busy_after", busy, 0);
        drain();

        // Reset while three are in flight; a new one on the first cycle after release.
        for (int i = 0; i < 3; i++) send_rand(10'(200 + i));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out0", out0, 0);
        chk("midrst_out_idx", out_idx, 0);
        drive(32'd7000, 32'd1000, MONT1, 10'd77, 32'd319, 32'd6000);
        drain();
        repeat (6) idle();

        // Random traffic with random bubbles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9, 0) < 6) send_rand(10'(i));
            else idle();
        end
        drain();
        repeat (3) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
